// File: rtl/ms6_producer_pkg.sv
// Shared types for the ms6_producer slice: section states and the signed data word.
package ms6_producer_types;

   typedef logic signed [31:0] data_t;

   typedef enum logic [1:0] {
      SECTION_IDLE,
      SECTION_COMPUTE,
      SECTION_PUBLISH
   } sections_t;

   localparam data_t DATA_MAX = 32'sh7FFF_FFFF;
   localparam data_t DATA_MIN = 32'sh8000_0000;

endpackage

// File: rtl/ms6_producer_sat_add.sv
// 32-bit signed adder; saturates when MS6_PRODUCER_SAT_EN is defined, wraps otherwise.
module ms6_sat_add
   import ms6_producer_types::*;
(
   input  data_t a,
   input  data_t b,
   output data_t sum
);

`ifdef MS6_PRODUCER_SAT_EN
   logic signed [32:0] wide;

   always_comb begin
      wide = {a[31], a} + {b[31], b};
      sum  = wide[31:0];
      // Sign disagreement between the guard bit and bit 31 means the 32-bit result overflowed.
      if (wide[32] != wide[31]) begin
         sum = wide[32] ? DATA_MIN : DATA_MAX;
      end
   end
`else
   always_comb begin
      sum = a + b;
   end
`endif

endmodule

// File: rtl/ms6_producer.sv
// Accumulating producer: takes a value from upstream, adds it to a running sum and
// publishes the sum REPEAT times. Build macro MS6_PRODUCER_SAT_EN selects saturating adds.
//
// state           | meaning
// SECTION_IDLE    | ready for b_in; transfer when b_in_sync is high
// SECTION_COMPUTE | one cycle: acc += val, first publish is registered here
// SECTION_PUBLISH | m_out_sync high; stays until REPEAT publish cycles are done
module ms6_producer
   import ms6_producer_types::*;
#(
   parameter int REPEAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  data_t      b_in,
   input  logic       b_in_sync,
   output logic       b_in_notify,
   output data_t      m_out,
   output logic       m_out_sync,
   output logic [7:0] pub_cnt
);

   localparam logic [3:0] RPT_LAST = 4'(REPEAT - 1);

   sections_t  state;
   data_t      acc;
   data_t      val;
   data_t      acc_sum;
   logic [3:0] rpt;

   ms6_sat_add u_add (
      .a   (acc),
      .b   (val),
      .sum (acc_sum)
   );

   // Outputs are registered one cycle ahead of the state they describe, so the first
   // publish is launched from COMPUTE and IDLE's notify is launched from the last publish.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SECTION_IDLE;
         acc         <= '0;
         val         <= '0;
         rpt         <= '0;
         m_out       <= '0;
         m_out_sync  <= 1'b0;
         pub_cnt     <= '0;
         b_in_notify <= 1'b1;
      end else begin
         case (state)
            SECTION_IDLE: begin
               m_out_sync <= 1'b0;
               if (b_in_sync) begin
                  val         <= b_in;
                  b_in_notify <= 1'b0;
                  state       <= SECTION_COMPUTE;
               end
            end
            SECTION_COMPUTE: begin
               acc        <= acc_sum;
               rpt        <= '0;
               m_out      <= acc_sum;
               m_out_sync <= 1'b1;
               pub_cnt    <= pub_cnt + 8'd1;
               state      <= SECTION_PUBLISH;
            end
            SECTION_PUBLISH: begin
               if (rpt == RPT_LAST) begin
                  m_out_sync  <= 1'b0;
                  b_in_notify <= 1'b1;
                  state       <= SECTION_IDLE;
               end else begin
                  rpt        <= rpt + 4'd1;
                  m_out_sync <= 1'b1;
                  pub_cnt    <= pub_cnt + 8'd1;
               end
            end
            default: begin
               m_out_sync  <= 1'b0;
               b_in_notify <= 1'b1;
               state       <= SECTION_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ms6_producer.sv
// Directed bench for ms6_producer: one REPEAT=2 instance and one REPEAT=1 instance.
module tb_ms6_producer;
   import ms6_producer_types::*;

   logic       clk = 1'b0;
   logic       rst2, rst1;
   data_t      b_in2, b_in1;
   logic       b_in_sync2, b_in_sync1;
   logic       b_in_notify2, b_in_notify1;
   data_t      m_out2, m_out1;
   logic       m_out_sync2, m_out_sync1;
   logic [7:0] pub_cnt2, pub_cnt1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ms6_producer #(.REPEAT(2)) dut2 (
      .clk(clk), .rst(rst2), .b_in(b_in2), .b_in_sync(b_in_sync2),
      .b_in_notify(b_in_notify2), .m_out(m_out2), .m_out_sync(m_out_sync2), .pub_cnt(pub_cnt2)
   );

   ms6_producer #(.REPEAT(1)) dut1 (
      .clk(clk), .rst(rst1), .b_in(b_in1), .b_in_sync(b_in_sync1),
      .b_in_notify(b_in_notify1), .m_out(m_out1), .m_out_sync(m_out_sync1), .pub_cnt(pub_cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst2 = 1'b1; rst1 = 1'b1;
      b_in2 = 32'sd99; b_in1 = 32'sd99;
      b_in_sync2 = 1'b0; b_in_sync1 = 1'b0;
      tick(); tick();
      rst2 = 1'b0; rst1 = 1'b0;
      tick(); tick();
      n_cmp++; if (b_in_notify2 !== 1'b1) begin n_err++; $display("FAIL reset_notify got %b want 1", b_in_notify2); end
      n_cmp++; if (m_out2 !== 32'sd0) begin n_err++; $display("FAIL reset_m_out got %0d want 0", m_out2); end
      n_cmp++; if (m_out_sync2 !== 1'b0) begin n_err++; $display("FAIL reset_sync got %b want 0", m_out_sync2); end
      n_cmp++; if (pub_cnt2 !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", pub_cnt2); end
      n_cmp++; if (b_in_notify1 !== 1'b1 || m_out_sync1 !== 1'b0 || pub_cnt1 !== 8'd0)
         begin n_err++; $display("FAIL reset_dut1 notify=%b sync=%b cnt=%0d want 1/0/0", b_in_notify1, m_out_sync1, pub_cnt1); end
   endtask

   task automatic test_basic();
      b_in2 = 32'sd5; b_in_sync2 = 1'b1;
      tick();                                   // t+1
      b_in_sync2 = 1'b0; b_in2 = 32'sd77;
      n_cmp++; if (b_in_notify2 !== 1'b0 || m_out_sync2 !== 1'b0)
         begin n_err++; $display("FAIL basic_t1 notify=%b sync=%b want 0/0", b_in_notify2, m_out_sync2); end
      tick();                                   // t+2
      n_cmp++; if (m_out_sync2 !== 1'b1 || m_out2 !== 32'sd5 || pub_cnt2 !== 8'd1)
         begin n_err++; $display("FAIL basic_t2 sync=%b m_out=%0d cnt=%0d want 1/5/1", m_out_sync2, m_out2, pub_cnt2); end
      tick();                                   // t+3
      n_cmp++; if (m_out_sync2 !== 1'b1 || m_out2 !== 32'sd5 || pub_cnt2 !== 8'd2 || b_in_notify2 !== 1'b0)
         begin n_err++; $display("FAIL basic_t3 sync=%b m_out=%0d cnt=%0d notify=%b want 1/5/2/0", m_out_sync2, m_out2, pub_cnt2, b_in_notify2); end
      tick();                                   // t+4
      n_cmp++; if (b_in_notify2 !== 1'b1 || m_out_sync2 !== 1'b0 || m_out2 !== 32'sd5 || pub_cnt2 !== 8'd2)
         begin n_err++; $display("FAIL basic_t4 notify=%b sync=%b m_out=%0d cnt=%0d want 1/0/5/2", b_in_notify2, m_out_sync2, m_out2, pub_cnt2); end
   endtask

   task automatic test_ignore_busy();
      b_in2 = 32'sd7; b_in_sync2 = 1'b1;
      tick();                                   // t+1, sync stays high
      b_in2 = 32'sd100;
      tick();                                   // t+2
      n_cmp++; if (m_out_sync2 !== 1'b1 || m_out2 !== 32'sd12)
         begin n_err++; $display("FAIL busy_t2 sync=%b m_out=%0d want 1/12", m_out_sync2, m_out2); end
      tick();                                   // t+3
      n_cmp++; if (m_out_sync2 !== 1'b1 || m_out2 !== 32'sd12 || pub_cnt2 !== 8'd4)
         begin n_err++; $display("FAIL busy_t3 sync=%b m_out=%0d cnt=%0d want 1/12/4", m_out_sync2, m_out2, pub_cnt2); end
      b_in_sync2 = 1'b0;
      tick();                                   // t+4
      tick();                                   // t+5, still idle: nothing captured
      n_cmp++; if (b_in_notify2 !== 1'b1 || m_out_sync2 !== 1'b0 || m_out2 !== 32'sd12)
         begin n_err++; $display("FAIL busy_idle notify=%b sync=%b m_out=%0d want 1/0/12", b_in_notify2, m_out_sync2, m_out2); end
   endtask

   task automatic test_overflow();
      data_t exp_ovf;
`ifdef MS6_PRODUCER_SAT_EN
      exp_ovf = 32'sh7FFF_FFFF;
`else
      exp_ovf = 32'sh8000_0000;
`endif
      b_in2 = 32'sh7FFF_FFF3; b_in_sync2 = 1'b1;  // 12 + this = 0x7FFFFFFF
      tick(); b_in_sync2 = 1'b0;
      tick();
      n_cmp++; if (m_out2 !== 32'sh7FFF_FFFF || m_out_sync2 !== 1'b1)
         begin n_err++; $display("FAIL ovf_max m_out=%h sync=%b want 7fffffff/1", m_out2, m_out_sync2); end
      tick(); tick();
      b_in2 = 32'sd1; b_in_sync2 = 1'b1;
      tick(); b_in_sync2 = 1'b0;
      tick();
      n_cmp++; if (m_out2 !== exp_ovf || m_out_sync2 !== 1'b1)
         begin n_err++; $display("FAIL ovf_add m_out=%h sync=%b want %h/1", m_out2, m_out_sync2, exp_ovf); end
      tick(); tick();
      n_cmp++; if (pub_cnt2 !== 8'd8 || b_in_notify2 !== 1'b1)
         begin n_err++; $display("FAIL ovf_cnt cnt=%0d notify=%b want 8/1", pub_cnt2, b_in_notify2); end
   endtask

   task automatic test_reset_mid_publish();
      b_in2 = 32'sd3; b_in_sync2 = 1'b1;
      tick(); b_in_sync2 = 1'b0;
      tick();                                   // first publish cycle
      n_cmp++; if (m_out_sync2 !== 1'b1)
         begin n_err++; $display("FAIL midrst_pre sync=%b want 1", m_out_sync2); end
      rst2 = 1'b1;
      #1;
      n_cmp++; if (m_out_sync2 !== 1'b0 || m_out2 !== 32'sd0 || pub_cnt2 !== 8'd0 || b_in_notify2 !== 1'b1)
         begin n_err++; $display("FAIL midrst_async sync=%b m_out=%0d cnt=%0d notify=%b want 0/0/0/1", m_out_sync2, m_out2, pub_cnt2, b_in_notify2); end
      tick();
      rst2 = 1'b0;
      tick(); tick();
      n_cmp++; if (m_out_sync2 !== 1'b0 || b_in_notify2 !== 1'b1)
         begin n_err++; $display("FAIL midrst_after sync=%b notify=%b want 0/1", m_out_sync2, b_in_notify2); end
      // acc must restart from 0
      b_in2 = 32'sd4; b_in_sync2 = 1'b1;
      tick(); b_in_sync2 = 1'b0;
      tick();
      n_cmp++; if (m_out2 !== 32'sd4 || m_out_sync2 !== 1'b1 || pub_cnt2 !== 8'd1)
         begin n_err++; $display("FAIL midrst_acc m_out=%0d sync=%b cnt=%0d want 4/1/1", m_out2, m_out_sync2, pub_cnt2); end
      tick(); tick();
   endtask

   task automatic test_wrap_repeat1();
      data_t sum = 32'sd0;
      data_t v;
      for (int i = 0; i < 256; i++) begin
         v = 32'(i * 3) - 32'sd100;
         sum = sum + v;
         b_in1 = v; b_in_sync1 = 1'b1;
         tick(); b_in_sync1 = 1'b0;
         tick();
         n_cmp++; if (m_out_sync1 !== 1'b1 || m_out1 !== sum || pub_cnt1 !== 8'(i + 1))
            begin n_err++; $display("FAIL wrap_pub i=%0d sync=%b m_out=%0d cnt=%0d want 1/%0d/%0d", i, m_out_sync1, m_out1, pub_cnt1, sum, 8'(i + 1)); end
         tick();
      end
      n_cmp++; if (pub_cnt1 !== 8'd0 || m_out_sync1 !== 1'b0 || b_in_notify1 !== 1'b1)
         begin n_err++; $display("FAIL wrap_end cnt=%0d sync=%b notify=%b want 0/0/1", pub_cnt1, m_out_sync1, b_in_notify1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_busy();
      test_overflow();
      test_reset_mid_publish();
      test_wrap_repeat1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ms6_producer.md
MS6_PRODUCER -- requirements
Module: ms6_producer

Interface
REQ-001 SHALL provide parameter REPEAT, default 2; publications per accepted input, legal range 1..15.
REQ-002 SHALL provide port clk  input  1  clock, rising-edge active.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port b_in  input  32 (signed integer)  blocking input data from upstream.
REQ-005 SHALL provide port b_in_sync  input  1  upstream offers b_in this cycle.
REQ-006 SHALL provide port b_in_notify  output  1  block ready to accept b_in.
REQ-007 SHALL provide port m_out  output  32 (signed integer)  master-out shared value for the downstream slave port (s_in).
REQ-008 SHALL provide port m_out_sync  output  1  m_out valid this cycle (drives downstream s_in_sync).
REQ-009 SHALL provide port pub_cnt  output  8  count of publications since reset.

Function
REQ-010 SHALL implement FSM over enum Sections {SECTION_IDLE, SECTION_COMPUTE, SECTION_PUBLISH}.
REQ-011 In SECTION_IDLE: b_in_notify=1; m_out_sync=0.
REQ-012 In SECTION_IDLE with b_in_sync=1: capture b_in into val; next state SECTION_COMPUTE. A transfer occurs only when b_in_notify and b_in_sync are both 1.
REQ-013 In SECTION_COMPUTE, one cycle only: acc <= acc + val; rpt <= 0; b_in_notify=0; next state SECTION_PUBLISH.
REQ-014 In SECTION_PUBLISH: m_out=acc and m_out_sync=1, registered, for exactly REPEAT consecutive cycles; b_in_notify=0.
REQ-015 Each publish cycle SHALL increment pub_cnt by 1, modulo 256 (255 -> 0).
REQ-016 After the REPEAT-th publish cycle, next state SECTION_IDLE. Latency from the b_in transfer to the first m_out_sync=1 is 2 cycles.
REQ-017 b_in_sync=1 outside SECTION_IDLE SHALL be ignored; b_in is not sampled.
REQ-018 m_out SHALL hold its last published value while m_out_sync=0.
REQ-019 acc is 32-bit signed; overflow behaviour is as defined in Configuration.

Reset
REQ-020 rst=1 SHALL asynchronously force: state=SECTION_IDLE, acc=0, val=0, rpt=0, m_out=0, m_out_sync=0, pub_cnt=0, b_in_notify=1 (derived from the IDLE state).
REQ-021 Reset asserted in any state, including mid-PUBLISH, SHALL abort the operation with no further m_out_sync pulse.

Configuration
REQ-022 Macro MS6_PRODUCER_SAT_EN defined: acc addition saturates to 0x7FFFFFFF / 0x80000000.
REQ-023 Macro MS6_PRODUCER_SAT_EN undefined: acc addition wraps modulo 2^32 (two's complement).

Structure
REQ-024 Sections enum and the 32-bit signed data type SHALL reside in package ms6_producer_types.
REQ-025 The adder SHALL be sub-module ms6_sat_add (32-bit signed a, b -> sum), with saturation gated by MS6_PRODUCER_SAT_EN.

Verification
REQ-026 Reset release, no input -> b_in_notify=1, m_out=0, m_out_sync=0, pub_cnt=0.
REQ-027 REPEAT=2; transfer b_in=5 at cycle t -> m_out=5 with m_out_sync=1 at t+2 and t+3, b_in_notify=1 at t+4; pub_cnt=2.
REQ-028 Then transfer b_in=7 -> m_out=12 published twice; b_in_sync held high during PUBLISH does not capture a new value.
REQ-029 acc=0x7FFFFFFF, transfer b_in=1 -> m_out=0x7FFFFFFF with MS6_PRODUCER_SAT_EN, 0x80000000 without.
REQ-030 rst pulsed during the first publish cycle -> m_out_sync=0 immediately, all registers 0, state IDLE.
REQ-031 REPEAT=1, 256 consecutive transfers -> pub_cnt wraps to 0; m_out equals the running sum at every publish.
